hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard detector for the pipelined MIPS core. Sits beside the ID stage.
- Consumes per-source "needed-at-stage" information from the ID instruction decoder.
- Tracks in-flight destination registers and the stage at which each result becomes forwardable, in a DEPTH-entry shift scoreboard.
- Produces the ID stall, the bubble-insert decision and per-source forwarding source stage. Generalises the fixed 2-bit read-stage decode to arbitrary pipeline depth and adds result-ready stages.

Parameters:
- REG_BITS, 5, register index width; register 0 never creates a hazard.
- DEPTH, 3, number of tracked stages after ID: index 1 = EX, 2 = MEM, 3 = WB.
- SW, 2, stage-index width; must satisfy 2^SW > DEPTH.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_BITS  source register rs.
- id_rs_need  in  1  rs is read.
- id_rs_stage  in  SW  stage index where rs is consumed: 0 = ID, 1 = EX, 2 = MEM, and so on.
- id_rt  in  REG_BITS  source register rt.
- id_rt_need  in  1  rt is read.
- id_rt_stage  in  SW  stage index where rt is consumed.
- id_wr  in  1  instruction writes a register.
- id_rd  in  REG_BITS  destination register.
- id_ready  in  SW  last stage index whose end produces the result: 1 = ALU, 2 = load.
- flush  in  1  kill the ID instruction (taken branch/jump).
- freeze  in  1  whole-pipeline hold (memory wait).
- stall  out  1  hold IF/ID and insert a bubble into EX.
- fwd_rs_src  out  SW  stage of youngest valid in-flight producer of rs; 0 = register file.
- fwd_rt_src  out  SW  same for rt.

Behaviour:
- Scoreboard entry e[p], p = 1..DEPTH: {valid, dst, ready}. On reset, all valid bits are 0 and all fields are 0.
- Match for source s: e[p].valid && e[p].dst == s && s != 0. The youngest match (lowest p) wins; older matches are ignored.
- Hazard for source s: need && id_valid && match exists && (p + stage_s <= e[p].ready), using the youngest match only. Perform the arithmetic at SW+1 bits so it cannot wrap.
- stall = (hazard_rs || hazard_rt) && !flush. stall is combinational from ID inputs and registered state, with zero latency. It is 0 during reset.
- fwd_x_src = p of the youngest match, else 0. It is combinational, is output regardless of the need bit, and is 0 during reset.
- Clock edge, freeze = 1: no state change.
- Clock edge, freeze = 0:
  - Shift: e[p+1] <= e[p] for p = 1..DEPTH-1; e[DEPTH] retires.
  - Then e[1] <= {id_valid && id_wr && id_rd != 0 && !stall && !flush, id_rd, id_ready}. Otherwise e[1] is a bubble with valid = 0.
- flush and stall are never both active in effect: flush wins, stall is forced to 0, and e[1] gets a bubble.
- A producer that has left e[DEPTH] is visible through the register-file write-before-read path. It never causes a hazard.
- id_ready > DEPTH is illegal. Assert in simulation only.
- An asynchronous reset mid-stall clears all entries and drops stall immediately.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[31:0] and stat_flush_cycles[31:0].
  - Each counts cycles with freeze = 0 and stall = 1, or flush = 1, respectively.
  - Counters saturate at all-ones and reset to 0.
- Undefined: no counters and no extra ports. Core behaviour is identical.

Decomposition:
- Shared header additions:
  - Stage index constants STAGE_ID = 0, STAGE_EX = 1, STAGE_MEM = 2, STAGE_WB = 3.
  - A conversion macro/function from the existing 2-bit read code (00 none, 01 EX, 10 MEM, 11 ID) to {need, stage}.
- One natural sub-module, hazard_src_check, instantiated twice (rs, rt).
  - It performs the youngest-match priority search and the hazard compare over the flattened scoreboard.
  - Outputs: hazard, fwd_src.

Test Plan:
- Load $2 in EX (ready 2), then `add $3,$2,$4` with rs needed at EX -> stall = 1 for exactly 1 cycle. fwd_rs_src = 1, then 2. The bubble shows valid = 0 in e[1].
- ALU write $5 (ready 1) in EX, then `beq $5,$0` needed at ID -> 1 stall cycle. After it, fwd_rs_src = 2 and stall = 0.
- Load $6 in EX, then `beq $6` at ID -> stall = 1 for 2 consecutive cycles, then 0 with fwd_rs_src = 3.
- Load $7 in EX, then `sw` with rt = $7 needed at MEM -> stall = 0, fwd_rt_src = 1.
- $7 written in e[1] and e[2] by different instructions, consumer reads $7 -> the youngest (p = 1) selects the outcome. Repeat with destination $0 -> no stall, no match.
- Hazard present with flush = 1 -> stall = 0 and e[1] bubble. Hazard with freeze held 3 cycles -> entries unchanged and stall stays 1. Assert rst mid-stall -> stall = 0 immediately and all entries invalid.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - stage constants and legacy read-code conversion for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int STAGE_ID  = 0;
  localparam int STAGE_EX  = 1;
  localparam int STAGE_MEM = 2;
  localparam int STAGE_WB  = 3;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_EX   = 2'b01,
    RD_MEM  = 2'b10,
    RD_ID   = 2'b11
  } rd_code_e;

  typedef struct packed {
    logic       need;
    logic [1:0] stage;
  } src_use_t;

  // Maps the old 2-bit decoder read code onto the {need, stage} form.
  function automatic src_use_t decode_read_code(input logic [1:0] code);
    src_use_t u;
    u.need = (code != RD_NONE);
    case (code)
      RD_EX:   u.stage = 2'(STAGE_EX);
      RD_MEM:  u.stage = 2'(STAGE_MEM);
      RD_ID:   u.stage = 2'(STAGE_ID);
      default: u.stage = 2'(STAGE_ID);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-side request/response bundle of the hazard scoreboard
// Optional statistics outputs appear when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int REG_BITS = 5,
  parameter int SW       = 2
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic                id_rs_need;
  logic [SW-1:0]       id_rs_stage;
  logic [REG_BITS-1:0] id_rt;
  logic                id_rt_need;
  logic [SW-1:0]       id_rt_stage;
  logic                id_wr;
  logic [REG_BITS-1:0] id_rd;
  logic [SW-1:0]       id_ready;
  logic                flush;
  logic                freeze;
  logic                stall;
  logic [SW-1:0]       fwd_rs_src;
  logic [SW-1:0]       fwd_rt_src;
`ifdef HAZARD_STATS_EN
  logic [31:0]         stat_stall_cycles;
  logic [31:0]         stat_flush_cycles;
`endif

  modport master (
    output id_valid, id_rs, id_rs_need, id_rs_stage, id_rt, id_rt_need, id_rt_stage,
           id_wr, id_rd, id_ready, flush, freeze,
    input  stall, fwd_rs_src, fwd_rt_src
`ifdef HAZARD_STATS_EN
    , input stat_stall_cycles, stat_flush_cycles
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rs_need, id_rs_stage, id_rt, id_rt_need, id_rt_stage,
           id_wr, id_rd, id_ready, flush, freeze,
    output stall, fwd_rs_src, fwd_rt_src
`ifdef HAZARD_STATS_EN
    , output stat_stall_cycles, stat_flush_cycles
`endif
  );
endinterface

// File: rtl/hazard_scoreboard_src_check.sv
// rtl/hazard_scoreboard_src_check.sv - youngest-match search and hazard compare for one source operand
module hazard_src_check #(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3,
  parameter int SW       = 2
) (
  input  logic [REG_BITS-1:0]       i_src,
  input  logic                      i_need,
  input  logic [SW-1:0]             i_stage,
  input  logic                      i_id_valid,
  input  logic [DEPTH-1:0]          i_sb_valid,
  input  logic [DEPTH*REG_BITS-1:0] i_sb_dst,
  input  logic [DEPTH*SW-1:0]       i_sb_ready,
  output logic                      o_hazard,
  output logic [SW-1:0]             o_fwd_src
);
  logic          w_found;
  logic [SW-1:0] w_p;
  logic [SW-1:0] w_rdy;

  always_comb begin
    w_found = 1'b0;
    w_p     = '0;
    w_rdy   = '0;
    // Walk oldest to youngest so the lowest matching index overrides.
    for (int p = DEPTH; p >= 1; p--) begin
      if (i_sb_valid[p-1] && (i_sb_dst[(p-1)*REG_BITS +: REG_BITS] == i_src) && (i_src != '0)) begin
        w_found = 1'b1;
        w_p     = SW'(p);
        w_rdy   = i_sb_ready[(p-1)*SW +: SW];
      end
    end
    o_hazard  = i_need && i_id_valid && w_found &&
                (({1'b0, w_p} + {1'b0, i_stage}) <= {1'b0, w_rdy});
    o_fwd_src = w_p;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard producing ID stall and forward-source stages
// Build option HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3,
  parameter int SW       = 2
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave bus
);
  logic [DEPTH-1:0]          r_valid;
  logic [DEPTH*REG_BITS-1:0] r_dst;
  logic [DEPTH*SW-1:0]       r_ready;

  logic w_hazard_rs;
  logic w_hazard_rt;
  logic w_stall;
  logic w_push;

  hazard_src_check #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .SW(SW)) u_rs (
    .i_src      (bus.id_rs),
    .i_need     (bus.id_rs_need),
    .i_stage    (bus.id_rs_stage),
    .i_id_valid (bus.id_valid),
    .i_sb_valid (r_valid),
    .i_sb_dst   (r_dst),
    .i_sb_ready (r_ready),
    .o_hazard   (w_hazard_rs),
    .o_fwd_src  (bus.fwd_rs_src)
  );

  hazard_src_check #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .SW(SW)) u_rt (
    .i_src      (bus.id_rt),
    .i_need     (bus.id_rt_need),
    .i_stage    (bus.id_rt_stage),
    .i_id_valid (bus.id_valid),
    .i_sb_valid (r_valid),
    .i_sb_dst   (r_dst),
    .i_sb_ready (r_ready),
    .o_hazard   (w_hazard_rt),
    .o_fwd_src  (bus.fwd_rt_src)
  );

  // Flush outranks stall: a killed instruction must never hold the front end.
  assign w_stall   = (w_hazard_rs || w_hazard_rt) && !bus.flush && !rst;
  assign w_push    = bus.id_valid && bus.id_wr && (bus.id_rd != '0) && !w_stall && !bus.flush;
  assign bus.stall = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dst   <= '0;
      r_ready <= '0;
    end else if (!bus.freeze) begin
      r_valid <= {r_valid[DEPTH-2:0], w_push};
      r_dst   <= {r_dst[(DEPTH-1)*REG_BITS-1:0], bus.id_rd};
      r_ready <= {r_ready[(DEPTH-1)*SW-1:0], bus.id_ready};
    end
  end

  a_ready_range : assert property (@(posedge clk) disable iff (rst)
    (bus.id_valid && bus.id_wr) |-> ({1'b0, bus.id_ready} <= (SW+1)'(DEPTH)));

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall <= '0;
      r_stat_flush <= '0;
    end else begin
      if (!bus.freeze && w_stall && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
      if (bus.flush && (r_stat_flush != '1))
        r_stat_flush <= r_stat_flush + 32'd1;
    end
  end

  assign bus.stat_stall_cycles = r_stat_stall;
  assign bus.stat_flush_cycles = r_stat_flush;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  hazard_scoreboard_if #(.REG_BITS(5), .SW(2)) bus ();

  hazard_scoreboard #(.REG_BITS(5), .DEPTH(3), .SW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] rs, input logic rsn, input logic [1:0] rss,
                       input logic [4:0] rt, input logic rtn, input logic [1:0] rts,
                       input logic wr, input logic [4:0] rd, input logic [1:0] rdy);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rs_need  = rsn;
    bus.id_rs_stage = rss;
    bus.id_rt       = rt;
    bus.id_rt_need  = rtn;
    bus.id_rt_stage = rts;
    bus.id_wr       = wr;
    bus.id_rd       = rd;
    bus.id_ready    = rdy;
    #2;
  endtask

  task automatic clear();
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    repeat (3) tick();
  endtask

  initial begin
    src_use_t u;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_valid", 32'(dut.r_valid), 32'd0);
    chk("reset_fwd_rs", 32'(bus.fwd_rs_src), 32'd0);
    tick();
    rst = 1'b0;

    u = decode_read_code(2'b11); chk("code_id", 32'(u), 32'b100);
    u = decode_read_code(2'b10); chk("code_mem", 32'(u), 32'b110);
    u = decode_read_code(2'b01); chk("code_ex", 32'(u), 32'b101);
    u = decode_read_code(2'b00); chk("code_none_need", 32'(u.need), 32'd0);

    // load $2 (ready 2), then add $3,$2,$4 reading rs at EX
    drive(1'b1, 5'd1, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd2, 2'd2);
    tick();
    drive(1'b1, 5'd2, 1'b1, 2'd1, 5'd4, 1'b1, 2'd1, 1'b1, 5'd3, 2'd1);
    chk("ld_add_stall1", 32'(bus.stall), 32'd1);
    chk("ld_add_fwd1", 32'(bus.fwd_rs_src), 32'd1);
    tick();
    chk("ld_add_bubble", 32'(dut.r_valid), 32'b010);
    chk("ld_add_stall2", 32'(bus.stall), 32'd0);
    chk("ld_add_fwd2", 32'(bus.fwd_rs_src), 32'd2);
    tick();
    chk("ld_add_push", 32'(dut.r_valid), 32'b101);
    clear();

    // ALU $5 (ready 1), then beq $5,$0 read at ID
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd5, 2'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("alu_beq_stall1", 32'(bus.stall), 32'd1);
    tick();
    chk("alu_beq_stall2", 32'(bus.stall), 32'd0);
    chk("alu_beq_fwd", 32'(bus.fwd_rs_src), 32'd2);
    clear();

    // load $6, then beq $6 at ID: two stall cycles
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd6, 2'd2);
    tick();
    drive(1'b1, 5'd6, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("ld_beq_stall1", 32'(bus.stall), 32'd1);
    tick();
    chk("ld_beq_stall2", 32'(bus.stall), 32'd1);
    tick();
    chk("ld_beq_stall3", 32'(bus.stall), 32'd0);
    chk("ld_beq_fwd", 32'(bus.fwd_rs_src), 32'd3);
    clear();

    // load $7, then sw with rt=$7 read at MEM
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 2'd2);
    tick();
    drive(1'b1, 5'd1, 1'b1, 2'd1, 5'd7, 1'b1, 2'd2, 1'b0, 5'd0, 2'd0);
    chk("ld_sw_stall", 32'(bus.stall), 32'd0);
    chk("ld_sw_fwd_rt", 32'(bus.fwd_rt_src), 32'd1);
    clear();

    // $7 in e[2] (ready 3) and e[1] (ready 1): youngest decides, no stall
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 2'd3);
    tick();
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 2'd1);
    tick();
    drive(1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("young_stall", 32'(bus.stall), 32'd0);
    chk("young_fwd", 32'(bus.fwd_rs_src), 32'd1);
    clear();

    // destination $0 never tracked or matched
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd0, 2'd2);
    tick();
    chk("r0_valid", 32'(dut.r_valid), 32'd0);
    drive(1'b1, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    chk("r0_fwd", 32'(bus.fwd_rs_src), 32'd0);
    clear();

    // hazard with flush: no stall, flushed writer becomes a bubble
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd6, 2'd2);
    tick();
    bus.flush = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd9, 2'd1);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(dut.r_valid), 32'b010);
    clear();

    // hazard held across 3 frozen cycles
    drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd6, 2'd2);
    tick();
    bus.freeze = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("frz_stall0", 32'(bus.stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_stall", 32'(bus.stall), 32'd1);
      chk("frz_valid", 32'(dut.r_valid), 32'b001);
      chk("frz_ready", 32'(dut.r_ready[1:0]), 32'd2);
    end
    bus.freeze = 1'b0;
    tick();
    chk("unfrz_valid", 32'(dut.r_valid), 32'b010);
    chk("unfrz_stall", 32'(bus.stall), 32'd1);

    // asynchronous reset in the middle of a stall
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_valid", 32'(dut.r_valid), 32'd0);
    chk("rst_fwd", 32'(bus.fwd_rs_src), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_stall", 32'(bus.stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
